// File: rtl/timer_compare_ctrl.sv
// Two-channel microsecond compare timer: one-shot or periodic compare channels,
// W1C pending bits and a registered level interrupt, behind a small local-bus register map.
module timer_compare_ctrl #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       us_count,
    input  logic              sel,
    input  logic              we,
    input  logic [AWIDTH-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata,
    output logic              irq
);

    localparam int unsigned NCH    = 2;
    localparam int unsigned WORD_W = 32;

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_STATUS  = 3'd1;
    localparam logic [2:0] A_CMP0    = 3'd2;
    localparam logic [2:0] A_PERIOD0 = 3'd3;
    localparam logic [2:0] A_CMP1    = 3'd4;
    localparam logic [2:0] A_PERIOD1 = 3'd5;
    localparam logic [2:0] A_NOW     = 3'd6;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } chan_state_e;

    // CTRL is held as per-channel fields; the register image is rebuilt on read
    logic [NCH-1:0]    en_q, en_d;
    logic [NCH-1:0]    per_q, per_d;
    logic [NCH-1:0]    ie_q, ie_d;
    logic [NCH-1:0]    pend_q, pend_d;
    logic [WORD_W-1:0] cmp_q [NCH];
    logic [WORD_W-1:0] cmp_d [NCH];
    logic [WORD_W-1:0] period_q [NCH];
    logic [WORD_W-1:0] period_d [NCH];
    chan_state_e       state_q [NCH];
    chan_state_e       state_d [NCH];
    logic              irq_q, irq_d;

    logic [2:0]        reg_sel;
    logic              bus_wr;
    logic [WORD_W-1:0] wword;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] diff [NCH];
    logic [NCH-1:0]    match;
    logic [NCH-1:0]    blocked;
    logic [NCH-1:0]    fire;
    logic              unused_bus_bits;

    assign reg_sel         = addr[4:2];
    assign bus_wr          = sel && we;
    assign wword           = wdata[WORD_W-1:0];
    assign unused_bus_bits = ^{addr, wdata};

    // Signed distance test gives a +/-2^31 window that survives us_count wrap and coarse steps
    always_comb begin
        for (int unsigned n = 0; n < NCH; n++) begin
            diff[n]    = us_count - cmp_q[n];
            match[n]   = (state_q[n] == ARMED) && !diff[n][WORD_W-1];
            blocked[n] = bus_wr && ((reg_sel == A_CTRL) ||
                                    (reg_sel == ((n == 0) ? A_CMP0 : A_CMP1)));
            fire[n]    = match[n] && !blocked[n];
        end
    end

    // Next-state: bus writes first, then match effects; a match sets PEND after any W1C
    always_comb begin
        en_d     = en_q;
        per_d    = per_q;
        ie_d     = ie_q;
        pend_d   = pend_q;
        cmp_d    = cmp_q;
        period_d = period_q;
        state_d  = state_q;
        irq_d    = 1'b0;

        if (bus_wr) begin
            case (reg_sel)
                A_CTRL: begin
                    en_d  = {wword[2], wword[0]};
                    per_d = {wword[3], wword[1]};
                    ie_d  = wword[5:4];
                end
                A_STATUS:  pend_d      = pend_q & ~wword[1:0];
                A_CMP0:    cmp_d[0]    = wword;
                A_PERIOD0: period_d[0] = wword;
                A_CMP1:    cmp_d[1]    = wword;
                A_PERIOD1: period_d[1] = wword;
                default: begin
                end
            endcase
        end

        for (int unsigned n = 0; n < NCH; n++) begin
            if (fire[n]) begin
                pend_d[n] = 1'b1;
                if (per_q[n] && (period_q[n] != '0)) begin
                    cmp_d[n] = cmp_q[n] + period_q[n];
                end else begin
                    en_d[n] = 1'b0;
                end
            end

            case (state_q[n])
                IDLE:    if (en_d[n])  state_d[n] = ARMED;
                ARMED:   if (!en_d[n]) state_d[n] = IDLE;
                default: state_d[n] = IDLE;
            endcase
        end

        irq_d = |(pend_d & ie_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= '0;
            per_q  <= '0;
            ie_q   <= '0;
            pend_q <= '0;
            irq_q  <= 1'b0;
            for (int unsigned n = 0; n < NCH; n++) begin
                cmp_q[n]    <= '0;
                period_q[n] <= '0;
                state_q[n]  <= IDLE;
            end
        end else begin
            en_q     <= en_d;
            per_q    <= per_d;
            ie_q     <= ie_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
            cmp_q    <= cmp_d;
            period_q <= period_d;
            state_q  <= state_d;
        end
    end

    // Combinational read mux; deselected bus reads as zero
    always_comb begin
        rd_word = '0;
        case (reg_sel)
            A_CTRL:    rd_word = WORD_W'({ie_q, per_q[1], en_q[1], per_q[0], en_q[0]});
            A_STATUS:  rd_word = WORD_W'(pend_q);
            A_CMP0:    rd_word = cmp_q[0];
            A_PERIOD0: rd_word = period_q[0];
            A_CMP1:    rd_word = cmp_q[1];
            A_PERIOD1: rd_word = period_q[1];
            A_NOW:     rd_word = us_count;
            default:   rd_word = '0;
        endcase
        rdata = sel ? XLEN'(rd_word) : '0;
    end

    assign irq = irq_q;

endmodule

// File: doc/timer_compare_ctrl.md
TIMER_COMPARE_CTRL -- requirements
Module: timer_compare_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the local bus data width (>= 32).
REQ-002 The block SHALL have parameter AWIDTH, default 32, meaning the local bus address width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning a synchronous active-high reset.
REQ-005 The block SHALL have port us_count, input, 32, meaning the free-running microsecond count.
REQ-006 The block SHALL have port sel, input, 1, meaning this block is selected on the local bus.
REQ-007 The block SHALL have port we, input, 1, meaning write strobe, valid only when sel=1.
REQ-008 The block SHALL have port addr, input, AWIDTH, meaning the byte address; only addr[4:2] are decoded.
REQ-009 The block SHALL have port wdata, input, XLEN, meaning write data; only bits [31:0] are used.
REQ-010 The block SHALL have port rdata, output, XLEN, meaning read data.
REQ-011 The block SHALL have port irq, output, 1, meaning a level interrupt request.

Function
REQ-012 The block SHALL decode addr[4:2] as follows:
- 0 CTRL: bit0 EN0, bit1 PER0MODE, bit2 EN1, bit3 PER1MODE, bit4 IE0, bit5 IE1.
- 1 STATUS: bit0 PEND0, bit1 PEND1; write-1-to-clear.
- 2 CMP0, 3 PERIOD0, 4 CMP1, 5 PERIOD1.
- 6 NOW (read-only us_count).
- 7 reserved; reads 0, writes ignored.
REQ-013 rdata SHALL be combinational: the selected register zero-extended to XLEN when sel=1, else all zeros; unused CTRL/STATUS bits SHALL read 0.
REQ-014 A write (sel=1, we=1) SHALL update the addressed register at the next clk edge; writes to NOW SHALL be ignored.
REQ-015 Each channel n SHALL have a state machine IDLE/ARMED. IDLE->ARMED on the edge where ENn becomes 1; ARMED->IDLE when ENn becomes 0 or on a one-shot fire.
REQ-016 Match for channel n SHALL be "ARMED and (us_count - CMPn) interpreted as signed 32-bit >= 0". This tolerates us_count steps >1 and 32-bit wrap-around, with a +/-2^31 window.
REQ-017 On a match edge, PENDn SHALL be set. If PERnMODE=1 and PERIODn!=0, CMPn SHALL become CMPn+PERIODn (mod 2^32) and the channel SHALL stay ARMED. Otherwise ENn SHALL be cleared and the channel SHALL go IDLE.
REQ-018 Match latency: us_count satisfying REQ-016 at edge t SHALL give PENDn=1 after edge t+1; irq SHALL be registered and be 1 after that same edge.
REQ-019 irq SHALL be (PEND0 & IE0) | (PEND1 & IE1), held in a flop updated every cycle from next-state values.
REQ-020 On the same edge, a bus write to CMPn or CTRL SHALL take priority over a match on channel n: the match is suppressed and the written value is used.
REQ-021 On the same edge, a STATUS W1C clear and a new match on that channel SHALL leave PENDn=1 (set wins).
REQ-022 Writing CTRL with ENn=1 while the channel is already ARMED SHALL keep it ARMED with no restart side effects.
REQ-023 The two channels SHALL operate independently and may fire on the same edge.

Reset
REQ-024 While rst=1 at an edge, the block SHALL set CTRL=0, STATUS=0, CMP0=CMP1=0, PERIOD0=PERIOD1=0, both channels IDLE and irq=0. Bus writes on that edge SHALL be ignored.
REQ-025 After reset, rdata SHALL be 0 when sel=0 and NOW SHALL read us_count.
REQ-026 Reset asserted mid-operation (ARMED, PEND set) SHALL clear all state on that edge. No fire SHALL occur until the channel is re-enabled after rst is deasserted.

Verification
REQ-027 The bench SHALL cover a one-shot: CMP0=100, CTRL=0x11, us_count ramps by 4 from 0 -> PEND0=1 and irq=1 one edge after us_count=100; EN0 reads 0; no second fire.
REQ-028 The bench SHALL cover periodic mode: CMP1=10, PERIOD1=10, CTRL=0x2C, us_count +1/cycle -> fires at 10, 20, 30; CMP1 reads 40 after the third fire.
REQ-029 The bench SHALL cover wrap-around: CMP0=0x00000005, us_count stepping from 0xFFFFFFF8 by 4 -> no fire before wrap; fires one edge after us_count=0x00000008.
REQ-030 The bench SHALL cover W1C collisions: with PEND0=1, write STATUS=0x1 -> PEND0=0, irq=0 next edge; repeat on the edge of a new match -> PEND0 stays 1.
REQ-031 The bench SHALL cover a CMP write colliding with a match: on the match edge, write CMP0=500 -> no PEND0; later fires at us_count>=500.
REQ-032 The bench SHALL cover reset mid-run: assert rst for 1 cycle while ARMED with PEND1=1 -> all registers 0, irq=0; us_count passing the old CMP -> no fire.
